// File: rtl/preset_matrix_loader.sv
// Writes N_MAT DIM x DIM pattern matrices to RAM; first write the cycle after start, one element per mem_pronta cycle.
// Stalls on mem_pronta=0. Readback verification is included only when PRESET_VERIFY_EN is defined.
module preset_matrix_loader #(
  parameter int DATA_W    = 9,
  parameter int DIM       = 5,
  parameter int N_MAT     = 2,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        modo,
  input  logic [DATA_W-1:0] valor_const,
  input  logic              mem_pronta,
  input  logic [DATA_W-1:0] dado_leitura,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] dado_escrita,
  output logic              grava,
  output logic              le,
  output logic              ocupado,
  output logic              concluido,
  output logic              erro
);

  localparam int MSZ = DIM * DIM;
  localparam int T   = N_MAT * MSZ;
  localparam int KW  = (T > 1) ? $clog2(T) : 1;

  generate
    if ((longint'(BASE_ADDR) + longint'(T) > (longint'(1) << ADDR_W)) ||
        (DIM < 1) || (DIM > 16) || (N_MAT < 1) || (N_MAT > 4)) begin : g_bad_cfg
      $error("preset_matrix_loader: matrices do not fit the RAM or DIM/N_MAT out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
`ifdef PRESET_VERIFY_EN
    , S_VERIFY = 2'd3
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] cval_q, cval_d;
  logic [KW-1:0]     k_q, k_d, k_nx;
  logic [7:0]        i_q, i_d, i_nx;
  logic [3:0]        row_q, row_d, row_nx;
  logic [3:0]        col_q, col_d, col_nx;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic              grava_q, grava_d;
  logic              ocupado_q, ocupado_d;
  logic              concluido_q, concluido_d;
  logic              last_k;
`ifdef PRESET_VERIFY_EN
  logic              le_q, le_d;
  logic              erro_q, erro_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
`endif

  // Pattern value for in-matrix index i at (r, c); mode 0 wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] pat(input logic [1:0] m, input logic [DATA_W-1:0] cv,
                                             input logic [7:0] i, input logic [3:0] r,
                                             input logic [3:0] c);
    logic [8:0] ip1;
    ip1 = {1'b0, i} + 9'd1;
    case (m)
      2'd0:    pat = DATA_W'(ip1);
      2'd1:    pat = (r == c) ? DATA_W'(1) : '0;
      2'd2:    pat = '0;
      default: pat = cv;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cval_d      = cval_q;
    k_d         = k_q;
    i_d         = i_q;
    row_d       = row_q;
    col_d       = col_q;
    addr_d      = addr_q;
    wdat_d      = wdat_q;
    grava_d     = grava_q;
    ocupado_d   = ocupado_q;
    concluido_d = 1'b0;

    col_nx = (col_q == 4'(DIM - 1)) ? '0 : col_q + 4'd1;
    row_nx = (col_q == 4'(DIM - 1)) ? ((row_q == 4'(DIM - 1)) ? '0 : row_q + 4'd1) : row_q;
    i_nx   = (i_q == 8'(MSZ - 1)) ? '0 : i_q + 8'd1;
    k_nx   = k_q + KW'(1);
    last_k = (k_q == KW'(T - 1));

`ifdef PRESET_VERIFY_EN
    le_d      = le_q;
    erro_d    = erro_q;
    cmp_vld_d = 1'b0;
    cmp_exp_d = cmp_exp_q;
    // Read data returns one cycle after the accepted read; compare it here.
    if (cmp_vld_q && (dado_leitura != cmp_exp_q)) erro_d = 1'b1;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_WRITE;
          mode_d    = modo;
          cval_d    = valor_const;
          k_d       = '0;
          i_d       = '0;
          row_d     = '0;
          col_d     = '0;
          addr_d    = ADDR_W'(BASE_ADDR);
          wdat_d    = pat(modo, valor_const, 8'd0, 4'd0, 4'd0);
          grava_d   = 1'b1;
          ocupado_d = 1'b1;
`ifdef PRESET_VERIFY_EN
          erro_d    = 1'b0;
`endif
        end
      end
      S_WRITE: begin
        if (mem_pronta) begin
          if (last_k) begin
            grava_d = 1'b0;
`ifdef PRESET_VERIFY_EN
            state_d = S_VERIFY;
            le_d    = 1'b1;
            k_d     = '0;
            i_d     = '0;
            row_d   = '0;
            col_d   = '0;
            addr_d  = ADDR_W'(BASE_ADDR);
`else
            state_d = S_DONE;
`endif
          end else begin
            k_d    = k_nx;
            i_d    = i_nx;
            row_d  = row_nx;
            col_d  = col_nx;
            addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(k_nx);
            wdat_d = pat(mode_q, cval_q, i_nx, row_nx, col_nx);
          end
        end
      end
`ifdef PRESET_VERIFY_EN
      S_VERIFY: begin
        if (mem_pronta) begin
          cmp_vld_d = 1'b1;
          cmp_exp_d = pat(mode_q, cval_q, i_q, row_q, col_q);
          if (last_k) begin
            le_d    = 1'b0;
            state_d = S_DONE;
          end else begin
            k_d    = k_nx;
            i_d    = i_nx;
            row_d  = row_nx;
            col_d  = col_nx;
            addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(k_nx);
          end
        end
      end
`endif
      S_DONE: begin
        state_d     = S_IDLE;
        ocupado_d   = 1'b0;
        concluido_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      cval_q      <= '0;
      k_q         <= '0;
      i_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      wdat_q      <= '0;
      grava_q     <= 1'b0;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
`ifdef PRESET_VERIFY_EN
      le_q        <= 1'b0;
      erro_q      <= 1'b0;
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cval_q      <= cval_d;
      k_q         <= k_d;
      i_q         <= i_d;
      row_q       <= row_d;
      col_q       <= col_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
      grava_q     <= grava_d;
      ocupado_q   <= ocupado_d;
      concluido_q <= concluido_d;
`ifdef PRESET_VERIFY_EN
      le_q        <= le_d;
      erro_q      <= erro_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_exp_q   <= cmp_exp_d;
`endif
    end
  end

  assign endereco     = addr_q;
  assign dado_escrita = wdat_q;
  assign grava        = grava_q;
  assign ocupado      = ocupado_q;
  assign concluido    = concluido_q;

`ifdef PRESET_VERIFY_EN
  assign le   = le_q;
  assign erro = erro_q;
`else
  logic unused_rd;
  assign unused_rd = ^dado_leitura;
  assign le        = 1'b0;
  assign erro      = 1'b0;
`endif

endmodule

// File: tb/tb_preset_matrix_loader.sv
// Directed bench for preset_matrix_loader: bench RAM, write logger and hand-derived pattern model.
// Covers every fill mode, mem_pronta stalls, mid-run reset, busy start and optional readback.
module tb_preset_matrix_loader;

  localparam int DATA_W    = 9;
  localparam int DIM       = 5;
  localparam int N_MAT     = 2;
  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 0;
  localparam int T         = N_MAT * DIM * DIM;
`ifdef PRESET_VERIFY_EN
  localparam int LAT = 2 * T + 1;
`else
  localparam int LAT = T + 1;
`endif

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [1:0]        modo;
  logic [DATA_W-1:0] valor_const;
  logic              mem_pronta;
  logic [DATA_W-1:0] dado_leitura;
  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] dado_escrita;
  logic              grava;
  logic              le;
  logic              ocupado;
  logic              concluido;
  logic              erro;

  preset_matrix_loader #(
    .DATA_W(DATA_W), .DIM(DIM), .N_MAT(N_MAT), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .modo(modo), .valor_const(valor_const),
    .mem_pronta(mem_pronta), .dado_leitura(dado_leitura), .endereco(endereco),
    .dado_escrita(dado_escrita), .grava(grava), .le(le), .ocupado(ocupado),
    .concluido(concluido), .erro(erro)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bench RAM; corrupt flips bit 0 of the readback at address 7.
  logic [DATA_W-1:0] mem [0:255];
  bit corrupt = 1'b0;
  always @(posedge clk) begin
    if (grava && mem_pronta) mem[endereco] <= dado_escrita;
    if (le && mem_pronta)
      dado_leitura <= mem[endereco] ^ ((corrupt && endereco == 8'd7) ? 9'h001 : 9'h000);
  end

  bit pr_toggle = 1'b0;
  initial begin
    mem_pronta = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (pr_toggle) mem_pronta = ~mem_pronta;
      else mem_pronta = 1'b1;
    end
  end

  int wr_addr[$];
  int wr_dat[$];
  int wr_cyc[$];
  int done_cnt = 0;
  int done_cyc = 0;
  bit both_seen = 1'b0;
  bit le_seen = 1'b0;
  initial forever begin
    @(negedge clk);
    if (grava && mem_pronta) begin
      wr_addr.push_back(int'(endereco));
      wr_dat.push_back(int'(dado_escrita));
      wr_cyc.push_back(cyc);
    end
    if (concluido) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (grava && le) both_seen = 1'b1;
    if (le) le_seen = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int exp_dat(input int m, input int cv, input int k);
    int i, r, c;
    i = k % (DIM * DIM);
    r = i / DIM;
    c = i % DIM;
    case (m)
      0: exp_dat = (i + 1) % 512;
      1: exp_dat = (r == c) ? 1 : 0;
      2: exp_dat = 0;
      default: exp_dat = cv;
    endcase
  endfunction

  int base = 0;
  int done_base = 0;
  int start_cyc = 0;

  task automatic start_run(input logic [1:0] m, input logic [8:0] cv);
    @(posedge clk);
    #1;
    base = wr_addr.size();
    done_base = done_cnt;
    start_cyc = cyc;
    modo = m;
    valor_const = cv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    modo = ~m;
    valor_const = ~cv;
    chk("ocupado_after_start", 32'(ocupado), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == done_base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt > done_base), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_run(input string tag, input int m, input int cv, input bit chk_lat,
                           input bit exp_err);
    chk({tag, "_nwrites"}, 32'(wr_addr.size() - base), 32'(T));
    for (int k = 0; k < T && base + k < wr_addr.size(); k++) begin
      chk($sformatf("%s_addr[%0d]", tag, k), 32'(wr_addr[base + k]), 32'(BASE_ADDR + k));
      chk($sformatf("%s_dat[%0d]", tag, k), 32'(wr_dat[base + k]), 32'(exp_dat(m, cv, k)));
    end
    chk({tag, "_concluido_once"}, 32'(done_cnt - done_base), 32'd1);
    if (chk_lat && wr_cyc.size() > base) begin
      chk({tag, "_first_write_delay"}, 32'(wr_cyc[base] - start_cyc), 32'd1);
      chk({tag, "_done_latency"}, 32'(done_cyc - wr_cyc[base]), 32'(LAT));
    end
    chk({tag, "_idle_addr_hold"}, 32'(endereco), 32'(BASE_ADDR + T - 1));
    chk({tag, "_idle_ocupado"}, 32'(ocupado), 32'd0);
    chk({tag, "_idle_grava"}, 32'(grava), 32'd0);
    chk({tag, "_erro"}, 32'(erro), 32'(exp_err));
  endtask

  task automatic do_run(input string tag, input int m, input int cv, input bit chk_lat,
                        input bit exp_err);
    start_run(2'(m), 9'(cv));
    wait_done(tag);
    check_run(tag, m, cv, chk_lat, exp_err);
  endtask

  initial begin
    int n;
    int sz;
    rst_n = 1'b1;
    start = 1'b0;
    modo = 2'd0;
    valor_const = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_endereco", 32'(endereco), 32'd0);
    chk("rst_dado_escrita", 32'(dado_escrita), 32'd0);
    chk("rst_grava", 32'(grava), 32'd0);
    chk("rst_le", 32'(le), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_concluido", 32'(concluido), 32'd0);
    chk("rst_erro", 32'(erro), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    do_run("mode0", 0, 0, 1'b1, 1'b0);
    do_run("mode1", 1, 0, 1'b1, 1'b0);
    do_run("mode2", 2, 0, 1'b1, 1'b0);
    do_run("mode3", 3, 9'h1A5, 1'b1, 1'b0);

    pr_toggle = 1'b1;
    do_run("stall", 0, 0, 1'b0, 1'b0);
    pr_toggle = 1'b0;

    start_run(2'd0, 9'd0);
    n = 0;
    while (wr_addr.size() < base + 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached_w10", 32'(wr_addr.size() >= base + 10), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_endereco", 32'(endereco), 32'd0);
    chk("rst_mid_dado_escrita", 32'(dado_escrita), 32'd0);
    chk("rst_mid_grava", 32'(grava), 32'd0);
    chk("rst_mid_le", 32'(le), 32'd0);
    chk("rst_mid_ocupado", 32'(ocupado), 32'd0);
    chk("rst_mid_concluido", 32'(concluido), 32'd0);
    chk("rst_mid_erro", 32'(erro), 32'd0);
    @(negedge clk);
    sz = wr_addr.size();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_no_resume_writes", 32'(wr_addr.size()), 32'(sz));
    chk("rst_no_resume_ocupado", 32'(ocupado), 32'd0);
    chk("rst_no_concluido", 32'(done_cnt), 32'(done_base));
    do_run("after_rst", 0, 0, 1'b1, 1'b0);

    start_run(2'd0, 9'd0);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    modo = 2'd3;
    valor_const = 9'h055;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("busy_start");
    check_run("busy_start", 0, 0, 1'b1, 1'b0);

`ifdef PRESET_VERIFY_EN
    corrupt = 1'b1;
    do_run("vfy_bad", 0, 0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("vfy_erro_sticky", 32'(erro), 32'd1);
    corrupt = 1'b0;
    start_run(2'd1, 9'd0);
    chk("vfy_erro_cleared_on_start", 32'(erro), 32'd0);
    wait_done("vfy_clean");
    check_run("vfy_clean", 1, 0, 1'b1, 1'b0);
    chk("vfy_le_used", 32'(le_seen), 32'd1);
`else
    chk("le_never_high", 32'(le_seen), 32'd0);
`endif
    chk("grava_le_exclusive", 32'(both_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
